// File: rtl/hdmi_vram_filler_pkg.sv
// Shared constants, register map and FSM encoding for the VRAM rectangle-fill engine.
// Also holds the row-base helper used by the clip/setup logic.
package hdmi_vram_filler_pkg;

    localparam int          XLEN       = 32;
    localparam logic [31:0] VRAM_BASE  = 32'h0020_0000;
    localparam logic [9:0]  H_PIX      = 10'd320;
    localparam logic [7:0]  V_PIX      = 8'd180;
    localparam logic [15:0] ROW_STRIDE = 16'd320;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_POS    = 3'd2;
    localparam logic [2:0] REG_SIZE   = 3'd3;
    localparam logic [2:0] REG_COLOR  = 3'd4;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_IE    = 2;
    localparam int ST_DONE    = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } fill_state_e;

    // y*320 + x built from shifts so no multiplier is needed
    function automatic logic [15:0] row_base(input logic [7:0] y, input logic [8:0] x);
        return ({8'h00, y} << 4'd8) + ({8'h00, y} << 4'd6) + {7'h00, x};
    endfunction

endpackage

// File: rtl/hdmi_vram_filler_if.sv
// VRAM local-bus write port between the fill engine (master) and the HDMI bus mux (slave).
interface hdmi_vram_filler_if;
    import hdmi_vram_filler_pkg::*;

    logic            m_req;
    logic            m_gnt;
    logic            m_sel;
    logic [XLEN-1:0] m_addr;
    logic [2:0]      m_we;
    logic [XLEN-1:0] m_qin;

    modport master (output m_req, output m_sel, output m_addr, output m_we, output m_qin,
                    input  m_gnt);
    modport slave  (input  m_req, input  m_sel, input  m_addr, input  m_we, input  m_qin,
                    output m_gnt);

endinterface

// File: rtl/hdmi_fill_addrgen.sv
// Pixel address generator: walks a clipped rectangle row-major, one pixel per advance.
module hdmi_fill_addrgen
    import hdmi_vram_filler_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        adv,
    input  logic [15:0] base,
    input  logic [9:0]  wc,
    input  logic [7:0]  hc,
    output logic [15:0] pix_idx,
    output logic        last
);

    logic [9:0]  col_r;
    logic [7:0]  row_r;
    logic [15:0] row_base_r;
    logic [9:0]  wc_r;
    logic [7:0]  hc_r;
    logic        row_end_s;

    assign row_end_s = (col_r == (wc_r - 10'd1));
    assign last      = row_end_s && (row_r == (hc_r - 8'd1));
    assign pix_idx   = row_base_r + {6'h00, col_r};

    // Column/row counters and row-base accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r      <= 10'd0;
            row_r      <= 8'd0;
            row_base_r <= 16'd0;
            wc_r       <= 10'd0;
            hc_r       <= 8'd0;
        end else if (load) begin
            col_r      <= 10'd0;
            row_r      <= 8'd0;
            row_base_r <= base;
            wc_r       <= wc;
            hc_r       <= hc;
        end else if (adv) begin
            if (row_end_s) begin
                col_r      <= 10'd0;
                row_r      <= row_r + 8'd1;
                row_base_r <= row_base_r + ROW_STRIDE;
            end else begin
                col_r <= col_r + 10'd1;
            end
        end
    end

endmodule

// File: rtl/hdmi_vram_filler.sv
// Rectangle-fill engine top: register slave, clip logic and job FSM driving the VRAM write port.
module hdmi_vram_filler
    import hdmi_vram_filler_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sel,
    input  logic [XLEN-1:0]     addr,
    input  logic [2:0]          we,
    input  logic [XLEN-1:0]     qin,
    output logic [XLEN-1:0]     qout,
    hdmi_vram_filler_if.master  vram,
    output logic                irq
);

    fill_state_e state_r, state_s;
    logic        start_r, abort_r, ie_r, done_r, err_r, aborted_r;
    logic [8:0]  x0_r;
    logic [7:0]  y0_r, h_r, color_r, color_w_r;
    logic [9:0]  w_r, wc_s, rem_x_s;
    logic [7:0]  hc_s, rem_y_s;
    logic [2:0]  reg_sel_s;
    logic        wr_s, rd_s, ctrl_wr_s, status_wr_s, start_wr_s, busy_s, m_sel_s, last_s;
    logic        load_s, set_done_s, set_err_s, set_aborted_s;
    logic [15:0] base_s, pix_idx_s;
    logic [XLEN-1:0] rdata_s;
    logic        unused_s;

    assign reg_sel_s   = addr[4:2];
    assign wr_s        = sel && (we != 3'b000);
    assign rd_s        = sel && (we == 3'b000);
    assign ctrl_wr_s   = wr_s && (reg_sel_s == REG_CTRL);
    assign status_wr_s = wr_s && (reg_sel_s == REG_STATUS);
    assign busy_s      = (state_r != S_IDLE);
    // ABORT beats START in the same write; START while busy is dropped
    assign start_wr_s  = ctrl_wr_s && qin[CTRL_START] && !qin[CTRL_ABORT] && !busy_s;
    assign m_sel_s     = (state_r == S_FILL) && vram.m_gnt;
    assign base_s      = row_base(y0_r, x0_r);
    assign unused_s    = ^{addr[31:5], addr[1:0], qin[31:24], qin[15:10]};

    assign vram.m_req  = (state_r == S_FILL);
    assign vram.m_sel  = m_sel_s;
    assign vram.m_we   = m_sel_s ? 3'b100 : 3'b000;
    assign vram.m_addr = VRAM_BASE | {16'h0000, pix_idx_s};
    assign vram.m_qin  = {24'h00_0000, color_w_r};
    assign irq         = done_r && ie_r;

    hdmi_fill_addrgen u_addrgen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_s),
        .adv     (m_sel_s),
        .base    (base_s),
        .wc      (wc_s),
        .hc      (hc_s),
        .pix_idx (pix_idx_s),
        .last    (last_s)
    );

    // Clip the programmed rectangle against the VRAM edges
    always_comb begin
        rem_x_s = H_PIX - {1'b0, x0_r};
        rem_y_s = V_PIX - y0_r;
        if ({1'b0, x0_r} >= H_PIX) begin
            wc_s = 10'd0;
        end else if (w_r < rem_x_s) begin
            wc_s = w_r;
        end else begin
            wc_s = rem_x_s;
        end
        if (y0_r >= V_PIX) begin
            hc_s = 8'd0;
        end else if (h_r < rem_y_s) begin
            hc_s = h_r;
        end else begin
            hc_s = rem_y_s;
        end
    end

    // Job FSM next-state and flag strobes
    always_comb begin
        state_s       = state_r;
        load_s        = 1'b0;
        set_done_s    = 1'b0;
        set_err_s     = 1'b0;
        set_aborted_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start_r) begin
                    state_s = S_SETUP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SETUP: begin
                if (abort_r) begin
                    state_s       = S_IDLE;
                    set_aborted_s = 1'b1;
                end else if ((wc_s == 10'd0) || (hc_s == 8'd0)) begin
                    state_s    = S_IDLE;
                    set_err_s  = 1'b1;
                    set_done_s = 1'b1;
                end else begin
                    state_s = S_FILL;
                    load_s  = 1'b1;
                end
            end
            S_FILL: begin
                if (abort_r) begin
                    state_s       = S_IDLE;
                    set_aborted_s = 1'b1;
                end else if (m_sel_s && last_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_FILL;
                end
            end
            S_DONE: begin
                state_s    = S_IDLE;
                set_done_s = 1'b1;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Register read mux
    always_comb begin
        rdata_s = {XLEN{1'b0}};
        case (reg_sel_s)
            REG_CTRL:   rdata_s = {29'h0, ie_r, 2'b00};
            REG_STATUS: rdata_s = {28'h0, aborted_r, err_r, done_r, busy_s};
            REG_POS:    rdata_s = {8'h00, y0_r, 7'h00, x0_r};
            REG_SIZE:   rdata_s = {8'h00, h_r, 6'h00, w_r};
            REG_COLOR:  rdata_s = {24'h00_0000, color_r};
            default:    rdata_s = {XLEN{1'b0}};
        endcase
    end

    // State register, register file, status flags and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            start_r   <= 1'b0;
            abort_r   <= 1'b0;
            ie_r      <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            aborted_r <= 1'b0;
            x0_r      <= 9'd0;
            y0_r      <= 8'd0;
            w_r       <= 10'd0;
            h_r       <= 8'd0;
            color_r   <= 8'd0;
            color_w_r <= 8'd0;
            qout      <= {XLEN{1'b0}};
        end else begin
            state_r <= state_s;
            start_r <= start_wr_s;
            abort_r <= ctrl_wr_s && qin[CTRL_ABORT] &&
                       ((state_r == S_SETUP) || (state_r == S_FILL));
            if (ctrl_wr_s) ie_r <= qin[CTRL_IE];
            if (wr_s && (reg_sel_s == REG_POS)) begin
                x0_r <= qin[8:0];
                y0_r <= qin[23:16];
            end
            if (wr_s && (reg_sel_s == REG_SIZE)) begin
                w_r <= qin[9:0];
                h_r <= qin[23:16];
            end
            if (wr_s && (reg_sel_s == REG_COLOR)) color_r <= qin[7:0];
            if (load_s) color_w_r <= color_r;
            if (set_done_s) begin
                done_r <= 1'b1;
            end else if (start_wr_s || (status_wr_s && qin[ST_DONE])) begin
                done_r <= 1'b0;
            end
            if (set_err_s) begin
                err_r <= 1'b1;
            end else if (start_wr_s) begin
                err_r <= 1'b0;
            end
            if (set_aborted_s) begin
                aborted_r <= 1'b1;
            end else if (start_wr_s) begin
                aborted_r <= 1'b0;
            end
            if (rd_s) qout <= rdata_s;
        end
    end

endmodule

// File: tb/tb_hdmi_vram_filler.sv
// Self-checking bench for hdmi_vram_filler: directed and random fill jobs vs. a rectangle model.
module tb_hdmi_vram_filler;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic [31:0] addr;
    logic [2:0]  we;
    logic [31:0] qin;
    logic [31:0] qout;
    logic        irq;

    hdmi_vram_filler_if vif ();

    hdmi_vram_filler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .addr  (addr),
        .we    (we),
        .qin   (qin),
        .qout  (qout),
        .vram  (vif),
        .irq   (irq)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int gnt_mode_v = 0;   // 0 hold high, 1 toggle, 2 random, 3 hold low
    int req_cycles = 0;
    int bad_we = 0;
    logic prev_irq = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_edge_q[$];
    logic [31:0] stall_addr_q[$];
    int          stall_idx_q[$];
    int          irq_rise_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Grant driver, changed shortly after each rising edge
    always @(posedge clk) begin
        #1;
        case (gnt_mode_v)
            0:       vif.m_gnt = 1'b1;
            1:       vif.m_gnt = (vif.m_gnt === 1'b1) ? 1'b0 : 1'b1;
            2:       vif.m_gnt = ($urandom_range(1, 0) == 1) ? 1'b1 : 1'b0;
            default: vif.m_gnt = 1'b0;
        endcase
    end

    // Bus-side observer: a write with m_sel high lands on the next rising edge
    always @(negedge clk) begin
        if (vif.m_sel === 1'b1) begin
            wr_addr_q.push_back(vif.m_addr);
            wr_data_q.push_back(vif.m_qin);
            wr_edge_q.push_back(edge_cnt + 1);
            if (vif.m_we !== 3'b100) bad_we <= bad_we + 1;
        end else begin
            if (vif.m_we !== 3'b000) bad_we <= bad_we + 1;
            if (vif.m_req === 1'b1) begin
                stall_addr_q.push_back(vif.m_addr);
                stall_idx_q.push_back(wr_addr_q.size());
            end
        end
        if (vif.m_req === 1'b1) req_cycles <= req_cycles + 1;
        if ((irq === 1'b1) && !prev_irq) irq_rise_q.push_back(edge_cnt);
        prev_irq <= (irq === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [4:0] a, input logic [31:0] d, output int e);
        @(negedge clk);
        sel = 1'b1; addr = {27'h0, a}; we = 3'b111; qin = d;
        e = edge_cnt + 1;
        @(negedge clk);
        sel = 1'b0; we = 3'b000; qin = 32'h0;
    endtask

    task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; addr = {27'h0, a}; we = 3'b000;
        @(negedge clk);
        sel = 1'b0;
        d = qout;
    endtask

    task automatic wait_idle(input string tag, output logic [31:0] st);
        repeat (2) @(negedge clk);
        st = 32'h1;
        for (int k = 0; k < 400; k++) begin
            reg_read(5'h04, st);
            if (st[0] == 1'b0) break;
        end
        check({tag, "_busy_timeout"}, {31'h0, st[0]}, 32'h0);
    endtask

    // Expected write addresses straight from the clip and row-major rules
    task automatic build_model(input int x0, input int y0, input int w, input int h, output int n);
        int wc, hc;
        wc = (x0 >= 320) ? 0 : ((w < 320 - x0) ? w : 320 - x0);
        hc = (y0 >= 180) ? 0 : ((h < 180 - y0) ? h : 180 - y0);
        exp_q.delete();
        for (int r = 0; r < hc; r++)
            for (int c = 0; c < wc; c++)
                exp_q.push_back(32'h0020_0000 + 32'((y0 + r) * 320 + x0 + c));
        n = wc * hc;
    endtask

    task automatic clear_obs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_edge_q.delete();
        stall_addr_q.delete(); stall_idx_q.delete(); irq_rise_q.delete();
    endtask

    task automatic run_job(input string tag, input int x0, input int y0, input int w,
                           input int h, input int color, input int mode);
        int n, s, d, req0;
        logic [31:0] st;
        logic [31:0] cdata;
        cdata = 32'(color & 255);
        reg_write(5'h08, 32'((y0 << 16) | x0), d);
        reg_write(5'h0C, 32'((h << 16) | w), d);
        reg_write(5'h10, 32'(color), d);
        build_model(x0, y0, w, h, n);
        clear_obs();
        gnt_mode_v = mode;
        req0 = req_cycles;
        reg_write(5'h00, 32'h5, s);
        wait_idle(tag, st);
        check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], exp_q[i]);
            check($sformatf("%s_data%0d", tag, i), wr_data_q[i], cdata);
        end
        for (int i = 0; i < stall_idx_q.size(); i++)
            if (stall_idx_q[i] < wr_addr_q.size())
                check($sformatf("%s_stall%0d", tag, i), stall_addr_q[i], wr_addr_q[stall_idx_q[i]]);
        check({tag, "_done"}, {31'h0, st[1]}, 32'h1);
        check({tag, "_err"}, {31'h0, st[2]}, (n == 0) ? 32'h1 : 32'h0);
        check({tag, "_aborted"}, {31'h0, st[3]}, 32'h0);
        check({tag, "_irq"}, {31'h0, irq}, 32'h1);
        check({tag, "_irq_rises"}, 32'(irq_rise_q.size()), 32'h1);
        if (mode == 0) begin
            check({tag, "_req_cycles"}, 32'(req_cycles - req0), 32'(n));
            if (irq_rise_q.size() > 0)
                check({tag, "_irq_edge"}, 32'(irq_rise_q[0]), 32'((n == 0) ? s + 2 : s + 3 + n));
            if (wr_edge_q.size() > 0) begin
                check({tag, "_first_edge"}, 32'(wr_edge_q[0]), 32'(s + 3));
                check({tag, "_last_edge"}, 32'(wr_edge_q[wr_edge_q.size() - 1]), 32'(s + 2 + n));
            end
        end
        reg_write(5'h04, 32'h2, d);
        check({tag, "_irq_w1c"}, {31'h0, irq}, 32'h0);
    endtask

    initial begin
        logic [31:0] st;
        int d, req0, x0, y0, w, h;
        sel = 1'b0; addr = 32'h0; we = 3'b000; qin = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_m_req", {31'h0, vif.m_req}, 32'h0);
        check("rst_m_sel", {31'h0, vif.m_sel}, 32'h0);
        check("rst_m_addr", vif.m_addr, 32'h0020_0000);
        check("rst_m_we", {29'h0, vif.m_we}, 32'h0);
        check("rst_m_qin", vif.m_qin, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_qout", qout, 32'h0);
        rst_n = 1'b1;
        reg_read(5'h04, st);
        check("rst_status", st, 32'h0);

        run_job("basic4x2", 0, 0, 4, 2, 8'h80, 0);
        run_job("clip_corner", 318, 179, 10, 5, 8'h3C, 0);
        run_job("x_off", 320, 0, 4, 4, 8'h11, 0);
        run_job("toggle3x3", 100, 50, 3, 3, 8'hA5, 1);

        // ABORT when idle and START+ABORT together do nothing
        clear_obs();
        reg_write(5'h00, 32'h2, d);
        reg_write(5'h00, 32'h3, d);
        repeat (4) @(negedge clk);
        reg_read(5'h04, st);
        check("idle_abort_status", st, 32'h0);
        check("idle_abort_nwrites", 32'(wr_addr_q.size()), 32'h0);

        // ABORT after five writes of a 16x16 job
        reg_write(5'h08, 32'h0, d);
        reg_write(5'h0C, 32'h0010_0010, d);
        reg_write(5'h10, 32'h77, d);
        clear_obs();
        gnt_mode_v = 0;
        reg_write(5'h00, 32'h5, d);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (wr_addr_q.size() >= 5) break;
        end
        gnt_mode_v = 3;
        reg_write(5'h00, 32'h6, d);
        repeat (4) @(negedge clk);
        gnt_mode_v = 0;
        repeat (6) @(negedge clk);
        reg_read(5'h04, st);
        check("abort_status", st, 32'h8);
        check("abort_nwrites", 32'(wr_addr_q.size()), 32'h5);
        for (int i = 0; i < 5 && i < wr_addr_q.size(); i++)
            check($sformatf("abort_addr%0d", i), wr_addr_q[i], 32'h0020_0000 + 32'(i));
        check("abort_irq", {31'h0, irq}, 32'h0);

        // Reset in the middle of a fill
        reg_write(5'h0C, 32'h0004_0008, d);
        clear_obs();
        gnt_mode_v = 0;
        reg_write(5'h00, 32'h5, d);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (wr_addr_q.size() >= 3) break;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_sel", {31'h0, vif.m_sel}, 32'h0);
        check("mid_rst_m_req", {31'h0, vif.m_req}, 32'h0);
        check("mid_rst_m_addr", vif.m_addr, 32'h0020_0000);
        check("mid_rst_m_we", {29'h0, vif.m_we}, 32'h0);
        check("mid_rst_m_qin", vif.m_qin, 32'h0);
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        check("mid_rst_qout", qout, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        reg_read(5'h04, st);
        check("post_rst_status", st, 32'h0);
        reg_read(5'h0C, st);
        check("post_rst_size", st, 32'h0);
        run_job("after_rst2x2", 5, 7, 2, 2, 8'hC3, 0);

        // Random jobs biased toward the right/bottom edges, random grant
        for (int j = 0; j < 8; j++) begin
            x0 = (j % 2 == 0) ? $urandom_range(325, 300) : $urandom_range(319, 0);
            y0 = (j % 2 == 0) ? $urandom_range(182, 172) : $urandom_range(179, 0);
            w  = $urandom_range(12, 0);
            h  = $urandom_range(5, 0);
            run_job($sformatf("rnd%0d", j), x0, y0, w, h, $urandom_range(255, 0), (j % 3 == 0) ? 0 : 2);
        end

        check("we_protocol", 32'(bad_we), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_vram_filler.md
# hdmi_vram_filler

Bus-mastering rectangle-fill engine that writes 8-bit grayscale pixels into the 320x180 HDMI VRAM (4x-downscaled 1280x720) through the local-bus slave port of the HDMI controller. The CPU programs position, size and colour through a small register slave, then starts a job. The engine requests the VRAM port via req/gnt, emits one byte write per granted cycle and raises a sticky done flag and interrupt.

## Interface
- XLEN, 32, local-bus data/address width
- H_PIX, 320, VRAM line width in pixels
- V_PIX, 180, VRAM line count
- clk  in  1  general logic clock (same as VRAM port A clock)
- rst_n  in  1  asynchronous, active-low reset
- sel  in  1  register slave select
- addr  in  XLEN  register address; only addr[4:2] decoded
- we  in  3  write enable; any nonzero value = 32-bit register write
- qin  in  XLEN  register write data
- qout  out  XLEN  register read data, registered
- m_req  out  1  VRAM port request
- m_gnt  in  1  VRAM port grant from the bus mux
- m_sel  out  1  VRAM write strobe
- m_addr  out  XLEN  0x0020_0000 | pixel index
- m_we  out  3  3'b100 (byte write) when m_sel, else 0
- m_qin  out  XLEN  {24'b0, colour}
- irq  out  1  DONE & IE level interrupt

## Operation
- Registers (offset):
  - 0x00 CTRL: [0] START (write-1, self-clearing), [1] ABORT (write-1), [2] IE.
  - 0x04 STATUS (RO, except W1C): [0] BUSY, [1] DONE (W1C), [2] ERR, [3] ABORTED.
  - 0x08 POS: X0 [8:0], Y0 [23:16].
  - 0x0C SIZE: W [9:0], H [23:16].
  - 0x10 COLOR: [7:0].
  - Other offsets read 0.
- FSM states:
  - IDLE: START goes to SETUP and clears DONE/ERR/ABORTED.
  - SETUP: one cycle; latches working copies of X0/Y0/W/H/COLOR.
    - Clip: Wc = min(W, H_PIX-X0), Hc = min(H, V_PIX-Y0); Wc = 0 if X0 >= H_PIX, Hc = 0 if Y0 >= V_PIX.
    - Row base = Y0*320 + X0, computed as (Y0<<8) + (Y0<<6) + X0 in 16 bits.
    - If Wc = 0 or Hc = 0: set ERR and DONE, go to IDLE, issue no writes. Otherwise go to FILL.
  - FILL: m_req = 1; m_sel = m_gnt.
    - Each cycle with m_sel high, the current pixel is written and the column counter advances.
    - At the end of a row, column counter = 0, row base += 320, row counter advances.
    - After the last pixel of the last row, go to DONE_ST.
  - DONE_ST: one cycle; m_req = 0; set DONE; go to IDLE.
- ABORT in SETUP/FILL: go to IDLE next cycle and set ABORTED. DONE is not set. Writes already issued stand.
- START while BUSY is ignored. ABORT while IDLE is ignored.
- START and ABORT in the same write: ABORT wins.
- POS/SIZE/COLOR writes while BUSY affect only the next job.
- BUSY = state != IDLE.
- Pixel order: row-major, ascending addresses.

## Timing
- Reset values: all registers 0, state IDLE, qout 0, m_req 0, m_sel 0, m_addr 0x0020_0000, m_we 0, m_qin 0, irq 0.
- Register read: qout valid the cycle after sel with we = 0.
- Register write takes effect at the sampling edge.
- START written at edge n: SETUP during cycle n+1, m_req high from cycle n+2.
- With m_gnt held high: first write at edge n+3, last write at edge n+2+Wc*Hc, DONE visible and irq high one cycle later.
- m_gnt low stalls the engine with no state change. m_addr/m_qin stay stable while stalled.
- m_gnt is ignored outside FILL.
- Reset mid-job: everything returns to reset values immediately. m_sel drops asynchronously.

## Structure
- Shared include hdmi_general.vh: VRAM_BASE (0x0020_0000), H_PIX, V_PIX, register offsets, STATUS/CTRL bit indices, FSM state encodings.
- One sub-module, hdmi_fill_addrgen: column/row counters, row-base accumulator, last-pixel flag, advance enable. The parent holds the register file, clip logic and FSM.

## Test plan
- X0=0, Y0=0, W=4, H=2, COLOR=0x80, gnt=1: exactly 8 writes to 0x200000–0x200003 and 0x200140–0x200143, data 0x80. DONE at start+11 cycles.
- X0=318, Y0=179, W=10, H=5: 2 writes (0x20E0FE, 0x20E0FF). DONE set, ERR clear.
- X0=320: no m_req, no writes. ERR and DONE set 2 cycles after START.
- 3x3 fill with m_gnt toggling 1,0,1,0…: same 9 addresses in order, no duplicates or skips, m_addr held during gnt=0.
- ABORT after 5 writes of a 16x16 fill: no further writes, ABORTED=1, DONE=0, irq stays 0 with IE=1.
- rst_n low mid-FILL, then a new 2x2 job: outputs at reset values during reset, new job correct, STATUS starts at 0.
